kgp_sum_pipe: RTL

KGP_SUM_PIPE -- requirements
Module: kgp_sum_pipe

---
 rtl/kgp_sum_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/kgp_sum_pipe.sv
// Adder front/back end around an external carry-prefix network: encodes operands
// into KGP pairs, delays per-bit propagate alongside the network, and forms sum/flags.
module kgp_sum_pipe #(
  parameter int unsigned W   = 32,
  parameter int unsigned LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  output logic [2*W-1:0]   kgp_out,
  input  logic [2*W-1:0]   prefix_res,
  output logic             out_valid,
  output logic [W-1:0]     sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned DEPTH = LAT + 1;
  // Counter can momentarily hold LAT+2 under full throughput (accept and retire overlap).
  localparam int unsigned CW    = $clog2(LAT + 3);

  logic [W-1:0]   bx;
  logic [W-1:0]   prop;
  logic [2*W-1:0] kgp_next;

  logic [W-1:0]   p_dly [DEPTH];
  logic [DEPTH-1:0] cin_dly;
  logic [DEPTH-1:0] vld_dly;

  logic [W:0]     carry;
  logic [W-1:0]   res;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic           unused_prefix_hi;

  // Operand conditioning and KGP encoding; carry-in folded into pair 0.
  always_comb begin
    bx       = in_sub ? ~in_b : in_b;
    prop     = in_a ^ bx;
    kgp_next = '0;
    for (int i = 0; i < int'(W); i++) begin
      kgp_next[2*i +: 2] = {in_a[i] | bx[i], in_a[i] & bx[i]};
    end
    kgp_next[1:0] = ((in_a[0] & bx[0]) | (in_sub & prop[0])) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) kgp_out <= '0;
    else       kgp_out <= kgp_next;
  end

  // Valid shift register; only this part needs clearing to kill in-flight ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_dly <= '0;
    end else begin
      vld_dly[0] <= in_valid;
      for (int i = 1; i < int'(DEPTH); i++) vld_dly[i] <= vld_dly[i-1];
    end
  end

  always_ff @(posedge clk) begin
    p_dly[0]   <= prop;
    cin_dly[0] <= in_sub;
    for (int i = 1; i < int'(DEPTH); i++) begin
      p_dly[i]   <= p_dly[i-1];
      cin_dly[i] <= cin_dly[i-1];
    end
  end

  // Carry into bit i+1 comes from the low bit of resolved pair i.
  always_comb begin
    carry[0] = cin_dly[DEPTH-1];
    for (int i = 0; i < int'(W); i++) carry[i+1] = prefix_res[2*i];
    res = p_dly[DEPTH-1] ^ carry[W-1:0];
  end

  always_comb begin
    unused_prefix_hi = 1'b0;
    for (int i = 0; i < int'(W); i++) unused_prefix_hi = unused_prefix_hi ^ prefix_res[2*i+1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= vld_dly[DEPTH-1];
      if (vld_dly[DEPTH-1]) begin
        sum  <= res;
        cout <= carry[W];
        ovf  <= carry[W-1] ^ carry[W];
      end
    end
  end

  always_comb begin
    cnt_next = cnt;
    case ({in_valid, out_valid})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      busy <= (cnt_next != '0);
    end
  end

endmodule
